// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle right shifter: FSM encoding and
// the width/amount relationship.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int SHIFT_WIDTH   = 32;
  localparam int SHIFT_SHAMT_W = $clog2(SHIFT_WIDTH);

endpackage

// File: rtl/serial_shift_right.sv
// Serial SRL/SRA unit: shifts one bit position per clock, start/done handshake.
// WIDTH must equal 2**SHAMT_W.
module serial_shift_right
  import shift_pkg::*;
#(
  parameter int WIDTH   = SHIFT_WIDTH,
  parameter int SHAMT_W = SHIFT_SHAMT_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Arith,
  input  logic [WIDTH-1:0]   DataIn,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic [WIDTH-1:0]   DataOut,
  output logic               Busy,
  output logic               Done
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          acc_d   = DataIn;
          cnt_d   = Shamt;
          mode_d  = Arith;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          acc_d = {mode_q & acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
          cnt_d = cnt_q - SHAMT_W'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Handshake outputs are flopped from the next state so they line up
    // with the state register and never see an input combinationally.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign DataOut = acc_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_serial_shift_right.sv
// Directed bench for serial_shift_right: latency, fill mode, bounds, reset abort.
module tb_serial_shift_right;

  logic        Clk = 1'b0;
  logic        Reset, Start, Arith;
  logic [31:0] DataIn, DataOut;
  logic [4:0]  Shamt;
  logic        Busy, Done;

  int n_run  = 0;
  int n_fail = 0;

  serial_shift_right dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Arith(Arith),
    .DataIn(DataIn), .Shamt(Shamt), .DataOut(DataOut),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs and samples both land 1 time unit after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Issue one op; optionally keep Start high (with junk operands) in cycles 1..5.
  task automatic run_op(input string tag, input logic arith, input logic [31:0] din,
                        input logic [4:0] sh, input logic [31:0] exp, input bit hold);
    int cyc;
    bit seen;
    Start = 1'b1; Arith = arith; DataIn = din; Shamt = sh;
    step();  // cycle-0 edge
    cyc  = 1;
    seen = 0;
    if (hold) begin
      DataIn = 32'h1234_5678; Shamt = 5'd1; Arith = ~arith;
    end else
      Start = 1'b0;
    chk({tag, " busy_rise"}, {31'd0, Busy}, 32'd1);
    for (int k = 0; k < 40 && !seen; k++) begin
      if (Done) begin
        seen = 1;
        chk({tag, " done_cycle"}, cyc, 32'(sh) + 32'd2);
        chk({tag, " result"}, DataOut, exp);
      end else begin
        step();
        cyc++;
        if (hold && cyc > 5) Start = 1'b0;
      end
    end
    if (!seen) chk({tag, " timeout"}, 32'd0, 32'd1);
    Start = 1'b0;
    step();
    chk({tag, " done_pulse"}, {31'd0, Done}, 32'd0);
    chk({tag, " busy_fall"},  {31'd0, Busy}, 32'd0);
    chk({tag, " hold_result"}, DataOut, exp);
  endtask

  initial begin
    bit bad;
    Reset = 1'b1; Start = 1'b0; Arith = 1'b0; DataIn = '0; Shamt = '0;
    step(); step();
    Reset = 1'b0;

    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (DataOut !== 32'd0 || Busy !== 1'b0 || Done !== 1'b0) bad = 1;
    end
    chk("reset_idle", {31'd0, bad}, 32'd0);

    run_op("srl4",    1'b0, 32'h8000_0000, 5'd4,  32'h0800_0000, 0);
    run_op("sra4",    1'b1, 32'h8000_0000, 5'd4,  32'hF800_0000, 0);
    run_op("sra0",    1'b1, 32'h89AB_CDEF, 5'd0,  32'h89AB_CDEF, 0);
    run_op("sra31",   1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 0);
    run_op("srl31",   1'b0, 32'h8000_0000, 5'd31, 32'h0000_0001, 0);
    run_op("sra_pos", 1'b1, 32'h7F00_00F0, 5'd8,  32'h007F_0000, 0);
    run_op("srl_hold",1'b0, 32'h8000_0000, 5'd4,  32'h0800_0000, 1);

    // Abort a Shamt=10 shift with reset sampled at the end of cycle 3.
    Start = 1'b1; Arith = 1'b0; DataIn = 32'hFFFF_0000; Shamt = 5'd10;
    step();
    Start = 1'b0;
    step(); step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rst_mid data", DataOut, 32'd0);
    chk("rst_mid busy", {31'd0, Busy}, 32'd0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (Done !== 1'b0 || Busy !== 1'b0) bad = 1;
      step();
    end
    chk("rst_mid no_done", {31'd0, bad}, 32'd0);
    run_op("after_rst", 1'b0, 32'hFFFF_0000, 5'd10, 32'h003F_FFC0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
